// File: rtl/atm_core_param_if.sv
// Front-panel bus between the keypad/panel sequencer (master) and the ATM core (slave).
interface atm_core_param_if #(
    parameter int ACC_W = 4,
    parameter int PIN_W = 16,
    parameter int BAL_W = 32
);
    logic             start;
    logic [ACC_W-1:0] acc_num;
    logic [PIN_W-1:0] pin;
    logic             op_valid;
    logic [2:0]       operation;
    logic [BAL_W-1:0] amount;
    logic [PIN_W-1:0] new_pin;
    logic [BAL_W-1:0] balance;
    logic             success;
    logic             done;
    logic             locked;
    logic [2:0]       state;

    modport master (
        output start, acc_num, pin, op_valid, operation, amount, new_pin,
        input  balance, success, done, locked, state
    );

    modport slave (
        input  start, acc_num, pin, op_valid, operation, amount, new_pin,
        output balance, success, done, locked, state
    );
endinterface

// File: rtl/atm_core_param.sv
// Multi-account ATM transaction core: PIN/balance tables, session framing,
// per-account lockout, per-session withdrawal cap, deposit overflow guard, idle timeout.
module atm_core_param #(
    parameter int ACC_W     = 4,
    parameter int PIN_W     = 16,
    parameter int BAL_W     = 32,
    parameter int MAX_TRIES = 3,
    parameter int WD_LIMIT  = 5000,
    parameter int TIMEOUT   = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    atm_core_param_if.slave  bus
);
    localparam int NUM = 2**ACC_W;
    localparam int FW  = $clog2(MAX_TRIES + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam logic [BAL_W:0] LIMIT = (BAL_W+1)'(WD_LIMIT);

    typedef enum logic [2:0] {
        REJECT   = 3'd0,
        AUTH     = 3'd1,
        MENU     = 3'd2,
        BALANCE  = 3'd3,
        WITHDRAW = 3'd4,
        DEPOSIT  = 3'd5,
        CHPIN    = 3'd6,
        IDLE     = 3'd7
    } state_t;

    state_t           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [PIN_W-1:0] pin_q;
    logic [PIN_W-1:0] new_pin_q;
    logic [BAL_W-1:0] amount_q;
    logic [BAL_W-1:0] balance_q;
    logic [BAL_W-1:0] wd_total_q;
    logic [TW-1:0]    idle_cnt_q;
    logic             success_q;
    logic             done_q;
    logic             locked_q;

    logic [PIN_W-1:0] pin_tbl_q  [NUM];
    logic [BAL_W-1:0] bal_tbl_q  [NUM];
    logic [FW-1:0]    fail_tbl_q [NUM];
    logic [NUM-1:0]   lock_q;

    logic [BAL_W-1:0] cur_bal;
    logic [PIN_W-1:0] cur_pin;
    logic [BAL_W:0]   wd_sum_d;
    logic [BAL_W:0]   dep_sum_d;
    logic [FW-1:0]    fail_d;
    logic             wd_ok;
    logic             dep_ok;

    // NOTE: combinational logic uses blocking '=', every register below uses '<='.
    always_comb begin
        cur_bal   = bal_tbl_q[acc_q];
        cur_pin   = pin_tbl_q[acc_q];
        wd_sum_d  = {1'b0, wd_total_q} + {1'b0, amount_q};
        dep_sum_d = {1'b0, cur_bal} + {1'b0, amount_q};
        fail_d    = fail_tbl_q[acc_q] + 1'b1;
        wd_ok     = (amount_q != '0) && (amount_q <= cur_bal) && (wd_sum_d <= LIMIT);
        dep_ok    = (amount_q != '0) && !dep_sum_d[BAL_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            pin_q      <= '0;
            new_pin_q  <= '0;
            amount_q   <= '0;
            balance_q  <= '0;
            wd_total_q <= '0;
            idle_cnt_q <= '0;
            success_q  <= 1'b0;
            done_q     <= 1'b0;
            locked_q   <= 1'b0;
            lock_q     <= '0;
            // NOTE: the tables are flops, not RAM, because reset must restore every entry.
            for (int i = 0; i < NUM; i++) begin
                pin_tbl_q[i]  <= PIN_W'(123 + 1111 * i);
                bal_tbl_q[i]  <= BAL_W'(1000);
                fail_tbl_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        acc_q   <= bus.acc_num;
                        pin_q   <= bus.pin;
                        state_q <= AUTH;
                    end
                end
                AUTH: begin
                    if ((pin_q == cur_pin) && !lock_q[acc_q]) begin
                        state_q           <= MENU;
                        success_q         <= 1'b1;
                        done_q            <= 1'b1;
                        locked_q          <= 1'b0;
                        fail_tbl_q[acc_q] <= '0;
                        wd_total_q        <= '0;
                        balance_q         <= cur_bal;
                        idle_cnt_q        <= '0;
                    end else begin
                        state_q <= REJECT;
                        // Counting stops once locked so the counter cannot wrap.
                        if ((pin_q != cur_pin) && !lock_q[acc_q]) begin
                            fail_tbl_q[acc_q] <= fail_d;
                            if (fail_d >= FW'(MAX_TRIES)) lock_q[acc_q] <= 1'b1;
                        end
                    end
                end
                REJECT: begin
                    state_q   <= IDLE;
                    success_q <= 1'b0;
                    done_q    <= 1'b1;
                    locked_q  <= lock_q[acc_q];
                end
                MENU: begin
                    if (bus.op_valid) begin
                        amount_q   <= bus.amount;
                        new_pin_q  <= bus.new_pin;
                        idle_cnt_q <= '0;
                        case (bus.operation)
                            3'd1: state_q <= WITHDRAW;
                            3'd2: state_q <= CHPIN;
                            3'd3: state_q <= BALANCE;
                            3'd5: state_q <= DEPOSIT;
                            3'd7: begin
                                state_q   <= IDLE;
                                success_q <= 1'b1;
                                done_q    <= 1'b1;
                            end
                            default: begin
                                success_q <= 1'b0;
                                done_q    <= 1'b1;
                            end
                        endcase
                    end else if (idle_cnt_q == TW'(TIMEOUT - 1)) begin
                        state_q   <= IDLE;
                        success_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + 1'b1;
                    end
                end
                WITHDRAW: begin
                    state_q    <= MENU;
                    done_q     <= 1'b1;
                    idle_cnt_q <= '0;
                    success_q  <= wd_ok;
                    if (wd_ok) begin
                        bal_tbl_q[acc_q] <= cur_bal - amount_q;
                        balance_q        <= cur_bal - amount_q;
                        wd_total_q       <= wd_sum_d[BAL_W-1:0];
                    end else begin
                        balance_q <= cur_bal;
                    end
                end
                DEPOSIT: begin
                    state_q    <= MENU;
                    done_q     <= 1'b1;
                    idle_cnt_q <= '0;
                    success_q  <= dep_ok;
                    if (dep_ok) begin
                        bal_tbl_q[acc_q] <= dep_sum_d[BAL_W-1:0];
                        balance_q        <= dep_sum_d[BAL_W-1:0];
                    end else begin
                        balance_q <= cur_bal;
                    end
                end
                CHPIN: begin
                    state_q    <= MENU;
                    done_q     <= 1'b1;
                    idle_cnt_q <= '0;
                    balance_q  <= cur_bal;
                    success_q  <= (new_pin_q != cur_pin);
                    if (new_pin_q != cur_pin) pin_tbl_q[acc_q] <= new_pin_q;
                end
                BALANCE: begin
                    state_q    <= MENU;
                    done_q     <= 1'b1;
                    idle_cnt_q <= '0;
                    balance_q  <= cur_bal;
                    success_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.balance = balance_q;
    assign bus.success = success_q;
    assign bus.done    = done_q;
    assign bus.locked  = locked_q;
    assign bus.state   = state_q;
endmodule
